fighter_state_ctrl: RTL and testbench

//  Per-player move sequencer. Turns button inputs and hurt events into the 4-bit move state consumed by the sprite renderer.

---
 rtl/fighter_state_ctrl_pkg.sv | 37 +++
 rtl/fighter_state_ctrl_phase_counter.sv | 36 +++
 rtl/fighter_state_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_fighter_state_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fighter_state_ctrl_pkg.sv
// ============================================================================
// fighter_state_ctrl_pkg : move-state encodings and output decode shared by
//                          the move sequencer, sprite renderer and collision checker
// Revision: 1.0
// ============================================================================
`default_nettype none

package fighter_state_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_BACKWARD   = 4'd1,
    S_FORWARD    = 4'd2,
    S_ATK_START  = 4'd3,
    S_ATK_ACTIVE = 4'd4,
    S_ATK_REC    = 4'd5,
    S_DIR_START  = 4'd6,
    S_DIR_ACTIVE = 4'd7,
    S_DIR_REC    = 4'd8,
    S_HITSTUN    = 4'd9,
    S_BLOCKSTUN  = 4'd10
  } move_state_t;

  // Recovery counter values at or below this accept a buffered attack
  localparam int BUFFER_WINDOW = 3;

  function automatic logic is_hitbox(input move_state_t s);
    return (s == S_ATK_ACTIVE) || (s == S_DIR_ACTIVE);
  endfunction

  function automatic logic is_actionable(input move_state_t s);
    return (s == S_IDLE) || (s == S_BACKWARD) || (s == S_FORWARD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fighter_state_ctrl_phase_counter.sv
// ============================================================================
// phase_counter : frame-tick enabled down-counter with load and zero flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module phase_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // Saturates at zero; a load always wins over the decrement
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tick) begin
      if (load) begin
        count <= load_val;
      end else if (count != '0) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/fighter_state_ctrl.sv
// ============================================================================
// fighter_state_ctrl : per-player move sequencer (buttons/hurt -> move state)
//   Optional attack input buffer in recovery: define ATTACK_BUFFER_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module fighter_state_ctrl
  import fighter_state_ctrl_pkg::*;
#(
  parameter int IS_MIRRORED      = 0,
  parameter int CNT_W            = 6,
  parameter int ATK_START_FRAMES = 4,
  parameter int ATK_ACT_FRAMES   = 3,
  parameter int ATK_REC_FRAMES   = 10,
  parameter int DIR_START_FRAMES = 6,
  parameter int DIR_ACT_FRAMES   = 4,
  parameter int DIR_REC_FRAMES   = 14,
  parameter int HITSTUN_FRAMES   = 20,
  parameter int BLOCK_FRAMES     = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  input  logic       hurt_in,
  output logic [3:0] state,
  output logic       hitbox_active,
  output logic       actionable
);

  localparam logic [CNT_W-1:0] L_ATK_START = CNT_W'(ATK_START_FRAMES - 1);
  localparam logic [CNT_W-1:0] L_ATK_ACT   = CNT_W'(ATK_ACT_FRAMES - 1);
  localparam logic [CNT_W-1:0] L_ATK_REC   = CNT_W'(ATK_REC_FRAMES - 1);
  localparam logic [CNT_W-1:0] L_DIR_START = CNT_W'(DIR_START_FRAMES - 1);
  localparam logic [CNT_W-1:0] L_DIR_ACT   = CNT_W'(DIR_ACT_FRAMES - 1);
  localparam logic [CNT_W-1:0] L_DIR_REC   = CNT_W'(DIR_REC_FRAMES - 1);
  localparam logic [CNT_W-1:0] L_HITSTUN   = CNT_W'(HITSTUN_FRAMES - 1);
  localparam logic [CNT_W-1:0] L_BLOCK     = CNT_W'(BLOCK_FRAMES - 1);

  move_state_t      state_q, state_d;
  logic             hitbox_q, actionable_q;
  logic             hurt_pend, atk_prev;
  logic             cnt_load, cnt_zero;
  logic [CNT_W-1:0] cnt_val, cnt;
  logic             fwd_raw, back_raw, fwd, back;
  logic             hurt_now, atk_edge;

  assign fwd_raw  = (IS_MIRRORED != 0) ? btn_left  : btn_right;
  assign back_raw = (IS_MIRRORED != 0) ? btn_right : btn_left;
  assign fwd      = fwd_raw & ~back_raw;
  assign back     = back_raw & ~fwd_raw;
  // A hurt arriving on the tick cycle itself is consumed on that tick
  assign hurt_now = hurt_pend | hurt_in;
  assign atk_edge = btn_attack & ~atk_prev;

`ifdef ATTACK_BUFFER_EN
  logic buf_q, buf_d;
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt;
`endif

  phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (frame_tick),
    .load     (cnt_load),
    .load_val (cnt_val),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
`ifdef ATTACK_BUFFER_EN
    buf_d    = buf_q;
`endif
    if (hurt_now) begin
      cnt_load = 1'b1;
      if (state_q == S_BACKWARD || (state_q == S_BLOCKSTUN && back)) begin
        state_d = S_BLOCKSTUN;
        cnt_val = L_BLOCK;
      end else begin
        state_d = S_HITSTUN;
        cnt_val = L_HITSTUN;
      end
`ifdef ATTACK_BUFFER_EN
      buf_d = 1'b0;
`endif
    end else if (is_actionable(state_q)) begin
      if (atk_edge && fwd) begin
        state_d  = S_DIR_START;
        cnt_load = 1'b1;
        cnt_val  = L_DIR_START;
      end else if (atk_edge) begin
        state_d  = S_ATK_START;
        cnt_load = 1'b1;
        cnt_val  = L_ATK_START;
      end else if (fwd) begin
        state_d = S_FORWARD;
      end else if (back) begin
        state_d = S_BACKWARD;
      end else begin
        state_d = S_IDLE;
      end
    end else if (!cnt_zero) begin
`ifdef ATTACK_BUFFER_EN
      if ((state_q == S_ATK_REC || state_q == S_DIR_REC) && atk_edge &&
          cnt <= CNT_W'(BUFFER_WINDOW)) begin
        buf_d = 1'b1;
      end
`endif
    end else begin
      cnt_load = 1'b1;
      case (state_q)
        S_ATK_START:  begin state_d = S_ATK_ACTIVE; cnt_val = L_ATK_ACT; end
        S_ATK_ACTIVE: begin state_d = S_ATK_REC;    cnt_val = L_ATK_REC; end
        S_DIR_START:  begin state_d = S_DIR_ACTIVE; cnt_val = L_DIR_ACT; end
        S_DIR_ACTIVE: begin state_d = S_DIR_REC;    cnt_val = L_DIR_REC; end
        S_ATK_REC, S_DIR_REC: begin
          state_d  = S_IDLE;
          cnt_load = 1'b0;
`ifdef ATTACK_BUFFER_EN
          // The exit tick itself still lies inside the buffer window
          if (buf_q || atk_edge) begin
            buf_d    = 1'b0;
            cnt_load = 1'b1;
            if (fwd) begin
              state_d = S_DIR_START;
              cnt_val = L_DIR_START;
            end else begin
              state_d = S_ATK_START;
              cnt_val = L_ATK_START;
            end
          end
`endif
        end
        default: begin
          state_d  = S_IDLE;
          cnt_load = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hitbox_q     <= 1'b0;
      actionable_q <= 1'b1;
      hurt_pend    <= 1'b0;
      atk_prev     <= 1'b0;
    end else if (frame_tick) begin
      state_q      <= state_d;
      hitbox_q     <= is_hitbox(state_d);
      actionable_q <= is_actionable(state_d);
      atk_prev     <= btn_attack;
      hurt_pend    <= 1'b0;
    end else if (hurt_in) begin
      hurt_pend    <= 1'b1;
    end
  end

`ifdef ATTACK_BUFFER_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q <= 1'b0;
    end else if (frame_tick) begin
      buf_q <= buf_d;
    end
  end
`endif

  assign state         = state_q;
  assign hitbox_active = hitbox_q;
  assign actionable    = actionable_q;

endmodule

`default_nettype wire

// File: tb/tb_fighter_state_ctrl.sv
// ============================================================================
// tb_fighter_state_ctrl : directed self-checking bench, player-1 and mirrored
//                         player-2 instances sharing the same stimulus
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fighter_state_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_attack = 1'b0;
  logic       hurt_in = 1'b0;
  logic [3:0] state, state_m;
  logic       hitbox_active, hitbox_m;
  logic       actionable, actionable_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fighter_state_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
    .hurt_in(hurt_in), .state(state), .hitbox_active(hitbox_active),
    .actionable(actionable)
  );

  fighter_state_ctrl #(.IS_MIRRORED(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
    .hurt_in(hurt_in), .state(state_m), .hitbox_active(hitbox_m),
    .actionable(actionable_m)
  );

  // One frame = 4 clocks; returns on a falling edge after outputs settled
  task automatic do_tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_hurt();
    @(negedge clk) hurt_in = 1'b1;
    @(negedge clk) hurt_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 4'd0 || hitbox_active !== 1'b0 || actionable !== 1'b1) begin
      errors++;
      $display("FAIL reset: state=%0d hb=%0b act=%0b, expected 0/0/1", state, hitbox_active, actionable);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_move();
    btn_right = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL move_no_tick: state=%0d expected 0", state);
    end
    for (int i = 0; i < 3; i++) begin
      do_tick();
      checks++;
      if (state !== 4'd2 || actionable !== 1'b1) begin
        errors++;
        $display("FAIL move_fwd tick%0d: state=%0d act=%0b expected 2/1", i, state, actionable);
      end
    end
    btn_right = 1'b0;
    do_tick();
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL move_release: state=%0d expected 0", state);
    end
  endtask

  task automatic test_attack();
    logic [3:0] exp;
    btn_attack = 1'b1;
    for (int i = 0; i < 18; i++) begin
      do_tick();
      btn_attack = 1'b0;
      exp = (i < 4) ? 4'd3 : (i < 7) ? 4'd4 : (i < 17) ? 4'd5 : 4'd0;
      checks++;
      if (state !== exp || hitbox_active !== (exp == 4'd4)) begin
        errors++;
        $display("FAIL attack tick%0d: state=%0d hb=%0b expected %0d/%0b", i, state, hitbox_active, exp, exp == 4'd4);
      end
    end
  endtask

  task automatic test_dir_attack();
    logic [3:0] exp;
    btn_right  = 1'b1;
    btn_attack = 1'b1;
    for (int i = 0; i < 26; i++) begin
      do_tick();
      btn_attack = 1'b0;
      if (i == 0) begin
        checks++;
        if (state_m !== 4'd3) begin
          errors++;
          $display("FAIL mirror_right_is_back: state=%0d expected 3", state_m);
        end
      end
      exp = (i < 6) ? 4'd6 : (i < 10) ? 4'd7 : (i < 24) ? 4'd8 : (i == 24) ? 4'd0 : 4'd2;
      checks++;
      if (state !== exp || hitbox_active !== (exp == 4'd7)) begin
        errors++;
        $display("FAIL dir_attack tick%0d: state=%0d hb=%0b expected %0d/%0b", i, state, hitbox_active, exp, exp == 4'd7);
      end
    end
    btn_right = 1'b0;
    do_tick();
  endtask

  task automatic test_mirror();
    do_reset();
    btn_left   = 1'b1;
    btn_attack = 1'b1;
    do_tick();
    checks++;
    if (state_m !== 4'd6 || state !== 4'd3) begin
      errors++;
      $display("FAIL mirror_dir: state_m=%0d state=%0d expected 6/3", state_m, state);
    end
    btn_left   = 1'b0;
    btn_attack = 1'b0;
    do_reset();
  endtask

  task automatic test_block();
    logic [3:0] exp;
    do_reset();
    btn_left = 1'b1;
    do_tick();
    pulse_hurt();
    checks++;
    if (state !== 4'd1) begin
      errors++;
      $display("FAIL block_pre: state=%0d expected 1", state);
    end
    do_tick();
    checks++;
    if (state !== 4'd10 || actionable !== 1'b0) begin
      errors++;
      $display("FAIL block_enter: state=%0d act=%0b expected 10/0", state, actionable);
    end
    repeat (4) do_tick();
    pulse_hurt();
    do_tick();
    for (int j = 0; j < 12; j++) begin
      do_tick();
      exp = (j < 11) ? 4'd10 : 4'd0;
      checks++;
      if (state !== exp) begin
        errors++;
        $display("FAIL block_restart tick%0d: state=%0d expected %0d", j, state, exp);
      end
    end
    btn_left = 1'b0;
    do_tick();
  endtask

  task automatic test_hurt_attack();
    logic [3:0] exp;
    do_reset();
    btn_attack = 1'b1;
    do_tick();
    btn_attack = 1'b0;
    repeat (4) do_tick();
    checks++;
    if (state !== 4'd4 || hitbox_active !== 1'b1) begin
      errors++;
      $display("FAIL hurt_attack_pre: state=%0d hb=%0b expected 4/1", state, hitbox_active);
    end
    pulse_hurt();
    do_tick();
    checks++;
    if (state !== 4'd9 || hitbox_active !== 1'b0) begin
      errors++;
      $display("FAIL hurt_attack_hit: state=%0d hb=%0b expected 9/0", state, hitbox_active);
    end
    for (int k = 0; k < 20; k++) begin
      do_tick();
      exp = (k < 19) ? 4'd9 : 4'd0;
      checks++;
      if (state !== exp) begin
        errors++;
        $display("FAIL hitstun tick%0d: state=%0d expected %0d", k, state, exp);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [3:0] exp;
    do_reset();
    @(negedge clk);
    hurt_in    = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    hurt_in    = 1'b0;
    frame_tick = 1'b0;
    checks++;
    if (state !== 4'd9) begin
      errors++;
      $display("FAIL hurt_same_tick: state=%0d expected 9", state);
    end
    for (int k = 0; k < 21; k++) begin
      do_tick();
      exp = (k < 19) ? 4'd9 : 4'd0;
      checks++;
      if (state !== exp) begin
        errors++;
        $display("FAIL same_tick_hitstun tick%0d: state=%0d expected %0d", k, state, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    btn_right  = 1'b1;
    btn_attack = 1'b1;
    do_tick();
    btn_attack = 1'b0;
    repeat (6) do_tick();
    checks++;
    if (state !== 4'd7 || hitbox_active !== 1'b1 || actionable !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pre: state=%0d hb=%0b act=%0b expected 7/1/0", state, hitbox_active, actionable);
    end
    btn_right = 1'b0;
    do_reset();
    checks++;
    if (state !== 4'd0 || hitbox_active !== 1'b0 || actionable !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: state=%0d hb=%0b act=%0b expected 0/0/1", state, hitbox_active, actionable);
    end
  endtask

  task automatic test_buffer();
    logic [3:0] exp;
`ifdef ATTACK_BUFFER_EN
    exp = 4'd3;
`else
    exp = 4'd0;
`endif
    do_reset();
    btn_attack = 1'b1;
    do_tick();
    btn_attack = 1'b0;
    repeat (14) do_tick();
    checks++;
    if (state !== 4'd5) begin
      errors++;
      $display("FAIL buffer_pre: state=%0d expected 5", state);
    end
    btn_attack = 1'b1;
    do_tick();
    btn_attack = 1'b0;
    do_tick();
    checks++;
    if (state !== 4'd5) begin
      errors++;
      $display("FAIL buffer_rec_last: state=%0d expected 5", state);
    end
    for (int k = 0; k < 2; k++) begin
      do_tick();
      checks++;
      if (state !== exp) begin
        errors++;
        $display("FAIL buffer_exit tick%0d: state=%0d expected %0d", k, state, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_move();
    test_attack();
    test_dir_attack();
    test_mirror();
    test_block();
    test_hurt_attack();
    test_same_cycle();
    test_reset_mid();
    test_buffer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
